// File: rtl/if_stage.sv
// Instruction-fetch stage: computes the next PC, drives the synchronous instruction
// SRAM and holds the fetched {pc, instr} pair steady for decode across stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_ds_reg_allow_in,
  input  logic [32:0] branch_data,
  input  logic [31:0] instr,
  output logic        fs_to_ds_reg_valid,
  output logic [63:0] fs_data,
  output logic [31:0] instr_sram_addr,
  output logic [31:0] instr_sram_wdata,
  output logic        instr_sram_en,
  output logic        instr_sram_wen
);

  logic        br_taken;
  logic [31:0] br_target;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        pending_br;
  logic [31:0] pending_target;
  logic        buf_valid;
  logic [31:0] instr_buf;

  logic        fs_allowin;
  logic        eff_taken;
  logic [31:0] eff_target;
  logic [31:0] nextpc;
  logic [31:0] fs_instr;

  assign br_taken  = branch_data[32];
  assign br_target = branch_data[31:0];

  // A live branch outranks one latched during an earlier stall cycle.
  assign eff_taken  = br_taken | pending_br;
  assign eff_target = br_taken ? br_target : pending_target;
  assign nextpc     = eff_taken ? eff_target : fs_pc + 32'd4;

  // The stage always finishes in one cycle, so it can accept whenever decode can.
  assign fs_allowin = ~fs_valid | fs_ds_reg_allow_in;

  assign instr_sram_addr  = nextpc;
  assign instr_sram_en    = ~reset & fs_allowin;
  assign instr_sram_wen   = 1'b0;
  assign instr_sram_wdata = 32'h0;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - 32'd4;
      pending_br     <= 1'b0;
      pending_target <= 32'h0;
      buf_valid      <= 1'b0;
    end else if (fs_allowin) begin
      fs_valid   <= 1'b1;
      fs_pc      <= nextpc;
      pending_br <= 1'b0;
      buf_valid  <= 1'b0;
    end else begin
      // Stalled with a valid instruction: remember redirects, freeze the SRAM word.
      if (br_taken) begin
        pending_br     <= 1'b1;
        pending_target <= br_target;
      end
      buf_valid <= 1'b1;
    end
  end

  // NOTE: the data buffer has no reset; buf_valid alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!reset && !fs_allowin && !buf_valid) begin
      instr_buf <= instr;
    end
  end

  // SRAM data is only valid the cycle after the read; later stall cycles use the copy.
  assign fs_instr = buf_valid ? instr_buf : instr;

  assign fs_to_ds_reg_valid = fs_valid;
  assign fs_data            = {fs_pc, fs_instr};

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a fetch-level reference model predicts every SRAM
// request and pushes the expected {pc, instr} pair; a monitor compares decode-side output.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_ds_reg_allow_in;
  logic [32:0] branch_data;
  logic [31:0] instr;
  logic        fs_to_ds_reg_valid;
  logic [63:0] fs_data;
  logic [31:0] instr_sram_addr;
  logic [31:0] instr_sram_wdata;
  logic        instr_sram_en;
  logic        instr_sram_wen;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  // Reference-model state: what has been fetched and which redirect is owed.
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_redirect;
  logic [31:0] m_target;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .reset              (reset),
    .fs_ds_reg_allow_in (fs_ds_reg_allow_in),
    .branch_data        (branch_data),
    .instr              (instr),
    .fs_to_ds_reg_valid (fs_to_ds_reg_valid),
    .fs_data            (fs_data),
    .instr_sram_addr    (instr_sram_addr),
    .instr_sram_wdata   (instr_sram_wdata),
    .instr_sram_en      (instr_sram_en),
    .instr_sram_wen     (instr_sram_wen)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous SRAM: returns the requested word the cycle after an enabled read,
  // and junk otherwise so a missing stall buffer shows up as changing data.
  initial begin
    logic        en_s;
    logic [31:0] a_s;
    instr = 32'h0;
    forever begin
      @(negedge clk);
      #3;
      en_s = instr_sram_en;
      a_s  = instr_sram_addr;
      @(posedge clk);
      #1;
      instr = en_s ? mem_word(a_s) : $urandom;
    end
  end

  // Monitor: whenever decode sees a valid instruction it must be the oldest outstanding fetch.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (fs_to_ds_reg_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("fs_data_unexpected", fs_data, 64'hx);
        end else begin
          check("fs_data", fs_data, exp_q[0]);
          if (fs_ds_reg_allow_in && !reset) void'(exp_q.pop_front());
        end
      end
      if (reset) exp_q.delete();
    end
  end

  // One clock of stimulus plus the model's prediction for the coming edge.
  task automatic cycle(input logic rst, input logic allow, input logic bt, input logic [31:0] tgt);
    logic        fetch;
    logic [31:0] exp_addr;
    @(negedge clk);
    reset              = rst;
    fs_ds_reg_allow_in = allow;
    branch_data        = {bt, tgt};
    #2;
    check("sram_wen", {63'h0, instr_sram_wen}, 64'h0);
    check("sram_wdata", {32'h0, instr_sram_wdata}, 64'h0);
    check("valid", {63'h0, fs_to_ds_reg_valid}, {63'h0, m_valid});
    if (rst) begin
      check("sram_en_reset", {63'h0, instr_sram_en}, 64'h0);
      m_valid    = 1'b0;
      m_pc       = RESET_PC - 32'd4;
      m_redirect = 1'b0;
    end else begin
      fetch = !m_valid || allow;
      if (bt) begin
        m_redirect = 1'b1;
        m_target   = tgt;
      end
      exp_addr = m_redirect ? m_target : m_pc + 32'd4;
      check("sram_en", {63'h0, instr_sram_en}, {63'h0, fetch});
      check("sram_addr", {32'h0, instr_sram_addr}, {32'h0, exp_addr});
      if (fetch) begin
        exp_q.push_back({exp_addr, mem_word(exp_addr)});
        m_pc       = exp_addr;
        m_valid    = 1'b1;
        m_redirect = 1'b0;
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    fs_ds_reg_allow_in = 1'b1;
    branch_data        = 33'h0;
    m_valid    = 1'b0;
    m_pc       = RESET_PC - 32'd4;
    m_redirect = 1'b0;
    m_target   = 32'h0;
    repeat (2) @(posedge clk);

    // Reset then straight-line fetch: 0x0, 0x4, 0x8 ...
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Branch held taken: every fetch goes to the same target.
    repeat (4) cycle(1'b0, 1'b1, 1'b1, 32'h2345_6788);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Plain stall, then resume sequentially.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // One-cycle branch pulse mid-stall must survive until the next fetch.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // PC wrap past the top of the address space.
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Reset during a stall with a branch pending discards everything.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0400);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 65),
            ($urandom_range(0, 99) < 20),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
